// File: rtl/siphash_pkg.sv
// siphash_pkg
//   Shared constants, the SipHash state type and the SipRound function
//   used by the pipelined SipHash-c-d core.
package siphash_pkg;

    localparam logic [63:0] IV0     = 64'h736f6d6570736575;
    localparam logic [63:0] IV1     = 64'h646f72616e646f6d;
    localparam logic [63:0] IV2     = 64'h6c7967656e657261;
    localparam logic [63:0] IV3     = 64'h7465646279746573;

    localparam logic [63:0] FIN_64  = 64'h00000000000000ff;
    localparam logic [63:0] FIN_128 = 64'h00000000000000ee;
    localparam logic [63:0] H1_128  = 64'h00000000000000dd;

    // Final block for an 8-byte message: length byte in the top lane, no tail bytes.
    localparam logic [63:0] LEN_BLK = 64'h0800000000000000;

    typedef struct packed {
        logic [63:0] v0;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [63:0] v3;
    } sip_state_t;

    // Left rotate: the upper half of {x,x} shifted left is x rotated by n.
    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n);
        logic [127:0] d;
        d = {x, x} << n;
        return d[127:64];
    endfunction

    function automatic sip_state_t sip_xor(input sip_state_t a, input sip_state_t b);
        return sip_state_t'(a ^ b);
    endfunction

    function automatic logic [63:0] sip_fold(input sip_state_t s);
        return s.v0 ^ s.v1 ^ s.v2 ^ s.v3;
    endfunction

    function automatic sip_state_t sip_round(input sip_state_t s);
        sip_state_t r;
        r    = s;
        r.v0 = r.v0 + r.v1;
        r.v1 = rotl(r.v1, 13);
        r.v1 = r.v1 ^ r.v0;
        r.v0 = rotl(r.v0, 32);
        r.v2 = r.v2 + r.v3;
        r.v3 = rotl(r.v3, 16);
        r.v3 = r.v3 ^ r.v2;
        r.v0 = r.v0 + r.v3;
        r.v3 = rotl(r.v3, 21);
        r.v3 = r.v3 ^ r.v0;
        r.v2 = r.v2 + r.v1;
        r.v1 = rotl(r.v1, 17);
        r.v1 = r.v1 ^ r.v2;
        r.v2 = rotl(r.v2, 32);
        return r;
    endfunction

endpackage

// File: rtl/siphash_round_reg.sv
// siphash_round_reg
//   One registered SipRound with its payload register. The mask is XORed
//   into the incoming state before the round, which is where the message,
//   length-block and finalisation constants get folded in.
// Ports
//   clk, rst_n        clock, async active-low reset
//   en                advance enable (whole pipeline moves together)
//   in_vld/out_vld    stage occupancy
//   in_state/mask     state from previous stage and pre-round XOR mask
//   in_pay/out_pay    sideband carried alongside the state
//   out_state         registered SipRound result
module siphash_round_reg
    import siphash_pkg::*;
#(
    parameter int PAY_W = 72
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_vld,
    input  sip_state_t       in_state,
    input  sip_state_t       mask,
    input  logic [PAY_W-1:0] in_pay,
    output logic             out_vld,
    output sip_state_t       out_state,
    output logic [PAY_W-1:0] out_pay
);

    sip_state_t round_out;

    assign round_out = sip_round(sip_xor(in_state, mask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_state <= '0;
            out_pay   <= '0;
        end else if (en) begin
            out_vld   <= in_vld;
            out_state <= round_out;
            out_pay   <= in_pay;
        end
    end

endmodule

// File: rtl/siphash_cd_stream.sv
// siphash_cd_stream
//   Fully pipelined SipHash-c-d over single 8-byte messages, one hash per
//   cycle, valid/ready on both sides. Every stage advances together on
//   adv = !out_valid || out_ready, so a stalled consumer freezes the pipe.
// Ports
//   clk, reset_n          clock, async active-low reset
//   key_we, key           key register load, key = {k1,k0}
//   in_valid/in_ready     input handshake, in_ready = adv
//   in_msg, in_tag        message word and opaque tag
//   out_valid/out_ready   output handshake
//   out_hash, out_tag     hash ({h1,h0} in 128-bit mode) and its tag
module siphash_cd_stream
    import siphash_pkg::*;
#(
    parameter int C_ROUNDS = 2,
    parameter int D_ROUNDS = 4,
    parameter int OUT128   = 0,
    parameter int TAG_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      key_we,
    input  logic [127:0]              key,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [63:0]               in_msg,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [64*(1+OUT128)-1:0]  out_hash,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int NSTG     = 2*C_ROUNDS + D_ROUNDS*(1+OUT128);
    localparam int HW       = 64*(1+OUT128);
    // Payload is {h0 (128-bit mode only), m, tag}.
    localparam int PAY_W    = TAG_W + 64 + 64*OUT128;
    localparam int H1_STAGE = (OUT128 != 0) ? 2*C_ROUNDS + D_ROUNDS : -1;

    logic             adv;
    logic [127:0]     key_q;
    sip_state_t       init_st;

    logic             ent_vld;
    sip_state_t       ent_st;
    logic [PAY_W-1:0] ent_pay;

    logic             stg_vld [NSTG];
    sip_state_t       stg_st  [NSTG];
    logic [PAY_W-1:0] stg_pay [NSTG];

    logic [HW-1:0]    hash_next;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        init_st.v0 = key_q[63:0]   ^ IV0;
        init_st.v1 = key_q[127:64] ^ IV1 ^ ((OUT128 != 0) ? FIN_128 : 64'd0);
        init_st.v2 = key_q[63:0]   ^ IV2;
        init_st.v3 = key_q[127:64] ^ IV3 ^ in_msg;
    end

    // Entry stage samples the key register before any same-cycle key_we
    // lands, so the accepted item keeps the old key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q   <= '0;
            ent_vld <= 1'b0;
            ent_st  <= '0;
            ent_pay <= '0;
        end else begin
            if (key_we) begin
                key_q <= key;
            end
            if (adv) begin
                ent_vld <= in_valid;
                if (in_valid) begin
                    ent_st  <= init_st;
                    ent_pay <= PAY_W'({in_msg, in_tag});
                end
            end
        end
    end

    genvar i;
    for (i = 0; i < NSTG; i++) begin : g_stage
        sip_state_t       s_in;
        sip_state_t       s_mask;
        logic             v_in;
        logic [PAY_W-1:0] p_in;
        logic [PAY_W-1:0] p_fix;
        logic [63:0]      m_in;

        if (i == 0) begin : g_first
            assign s_in = ent_st;
            assign v_in = ent_vld;
            assign p_in = ent_pay;
        end else begin : g_next
            assign s_in = stg_st[i-1];
            assign v_in = stg_vld[i-1];
            assign p_in = stg_pay[i-1];
        end

        assign m_in = p_in[TAG_W +: 64];

        // Stage C closes the message block and opens the length block,
        // stage 2C closes the length block and starts finalisation.
        always_comb begin
            s_mask = '0;
            if (i == C_ROUNDS) begin
                s_mask.v0 = m_in;
                s_mask.v3 = LEN_BLK;
            end
            if (i == 2*C_ROUNDS) begin
                s_mask.v0 = LEN_BLK;
                s_mask.v2 = (OUT128 != 0) ? FIN_128 : FIN_64;
            end
            if (i == H1_STAGE) begin
                s_mask.v1 = H1_128;
            end
        end

        // h0 is taken from the state entering the second finalisation pass.
        if (i == H1_STAGE) begin : g_h0
            assign p_fix = {sip_fold(s_in), p_in[TAG_W+63:0]};
        end else begin : g_pass
            assign p_fix = p_in;
        end

        siphash_round_reg #(
            .PAY_W (PAY_W)
        ) u_round (
            .clk       (clk),
            .rst_n     (reset_n),
            .en        (adv),
            .in_vld    (v_in),
            .in_state  (s_in),
            .mask      (s_mask),
            .in_pay    (p_fix),
            .out_vld   (stg_vld[i]),
            .out_state (stg_st[i]),
            .out_pay   (stg_pay[i])
        );
    end

    if (OUT128 != 0) begin : g_out128
        assign hash_next = {sip_fold(stg_st[NSTG-1]), stg_pay[NSTG-1][PAY_W-1 -: 64]};
    end else begin : g_out64
        assign hash_next = sip_fold(stg_st[NSTG-1]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_hash  <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= stg_vld[NSTG-1];
            if (stg_vld[NSTG-1]) begin
                out_hash <= hash_next;
                out_tag  <= stg_pay[NSTG-1][TAG_W-1:0];
            end
        end
    end

endmodule
